// File: rtl/traffic_interval_timer.sv
// traffic_interval_timer
//   Interval timer and car-sensor conditioner for the traffic-light controller.
//   A prescaler divides clk into ticks. st restarts the interval; ts and tl go
//   high once the tick count reaches the programmable short / long limits and
//   stay high until the next st. The raw loop detector is synchronised and
//   debounced into c.
// Ports
//   clk       clock
//   rst_n     synchronous active-low reset
//   st        restart interval (held high keeps the timer at 0)
//   cfg_we    limit write strobe
//   cfg_sel   0 = short limit, 1 = long limit
//   cfg_data  limit value in ticks (0 is stored as 1)
//   car_raw   asynchronous loop-detector input
//   ts, tl    short / long interval elapsed (levels)
//   c         debounced car present
//   elapsed   ticks since last st, saturating
module traffic_interval_timer #(
  parameter int unsigned P      = 1000,
  parameter int unsigned TW     = 8,
  parameter int unsigned TS_DEF = 3,
  parameter int unsigned TL_DEF = 20,
  parameter int unsigned DB     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [TW-1:0] cfg_data,
  input  logic          car_raw,
  output logic          ts,
  output logic          tl,
  output logic          c,
  output logic [TW-1:0] elapsed
);

  localparam int unsigned PW = $clog2(P);
  localparam int unsigned CW = (DB > 1) ? $clog2(DB) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(P - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB - 1);
  localparam logic [TW-1:0] EL_MAX   = '1;

  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] elapsed_q, elapsed_d;
  logic [TW-1:0] ts_lim_q, ts_lim_d;
  logic [TW-1:0] tl_lim_q, tl_lim_d;
  logic [TW-1:0] cfg_val;
  logic          tick;
  logic          sync1_q, car_s_q;
  logic          c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick = (pre_q == PRE_LAST) && !st;

    pre_d = pre_q + 1'b1;
    if (st || (pre_q == PRE_LAST)) pre_d = '0;

    elapsed_d = elapsed_q;
    if (st)                               elapsed_d = '0;
    else if (tick && elapsed_q != EL_MAX) elapsed_d = elapsed_q + 1'b1;

    // A zero limit would make the output assert together with st; clamp to 1.
    cfg_val  = (cfg_data == '0) ? TW'(1) : cfg_data;
    ts_lim_d = ts_lim_q;
    tl_lim_d = tl_lim_q;
    if (cfg_we) begin
      if (cfg_sel) tl_lim_d = cfg_val;
      else         ts_lim_d = cfg_val;
    end

    // Counter only runs while the synchronised input disagrees with c;
    // DB consecutive disagreeing samples flip c.
    c_d   = c_q;
    cnt_d = '0;
    if (car_s_q != c_q) begin
      if (cnt_q == CNT_LAST) c_d   = ~c_q;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q     <= '0;
      elapsed_q <= '0;
      ts_lim_q  <= TW'(TS_DEF);
      tl_lim_q  <= TW'(TL_DEF);
      sync1_q   <= 1'b0;
      car_s_q   <= 1'b0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pre_q     <= pre_d;
      elapsed_q <= elapsed_d;
      ts_lim_q  <= ts_lim_d;
      tl_lim_q  <= tl_lim_d;
      sync1_q   <= car_raw;
      car_s_q   <= sync1_q;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ts      = (elapsed_q >= ts_lim_q);
  assign tl      = (elapsed_q >= tl_lim_q);
  assign c       = c_q;
  assign elapsed = elapsed_q;

endmodule

// File: tb/tb_traffic_interval_timer.sv
// tb_traffic_interval_timer
//   Directed bench for traffic_interval_timer with P=4, TW=8, TS_DEF=3,
//   TL_DEF=5, DB=4. A cycle-count model predicts every output each cycle;
//   literal expectations pin the model at key points.
module tb_traffic_interval_timer;

  localparam int P  = 4;
  localparam int TW = 8;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst_n, st, cfg_we, cfg_sel, car_raw;
  logic [TW-1:0] cfg_data;
  logic          ts, tl, c;
  logic [TW-1:0] elapsed;

  int n_checks = 0;
  int n_pass   = 0;

  traffic_interval_timer #(
    .P(P), .TW(TW), .TS_DEF(3), .TL_DEF(5), .DB(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .st(st), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .car_raw(car_raw), .ts(ts), .tl(tl), .c(c),
    .elapsed(elapsed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: cycles since last st/reset, limits, raw-sample history.
  bit model_ok = 0;
  int m_cyc    = 0;
  int m_ts_lim = 3;
  int m_tl_lim = 5;
  bit m_c      = 0;
  bit hist [0:DB+1];

  function automatic int m_el();
    int e;
    e = m_cyc / P;
    return (e > 255) ? 255 : e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      model_ok = 1;
      m_cyc    = 0;
      m_ts_lim = 3;
      m_tl_lim = 5;
      m_c      = 0;
      for (int i = 0; i <= DB + 1; i++) hist[i] = 0;
    end else begin
      bit all_diff;
      if (st) m_cyc = 0;
      else    m_cyc++;
      if (cfg_we) begin
        if (cfg_sel) m_tl_lim = (cfg_data == 0) ? 1 : int'(cfg_data);
        else         m_ts_lim = (cfg_data == 0) ? 1 : int'(cfg_data);
      end
      for (int i = DB + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = car_raw;
      // Samples seen by the debouncer this edge were taken two edges earlier.
      all_diff = 1;
      for (int i = 2; i <= DB + 1; i++) if (hist[i] == m_c) all_diff = 0;
      if (all_diff) m_c = !m_c;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_elapsed", int'(elapsed), m_el());
      chk("model_ts", int'(ts), int'(m_el() >= m_ts_lim));
      chk("model_tl", int'(tl), int'(m_el() >= m_tl_lim));
      chk("model_c", int'(c), int'(m_c));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_st();
    st = 1'b1;
    step();
    st = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; st = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0;
    cfg_data = '0; car_raw = 1'b0;

    // 1. reset, then free run from 0
    repeat (2) step();
    chk("rst_ts", int'(ts), 0);
    chk("rst_tl", int'(tl), 0);
    chk("rst_c", int'(c), 0);
    chk("rst_elapsed", int'(elapsed), 0);
    rst_n = 1'b1;
    repeat (4) step();
    chk("freerun_elapsed", int'(elapsed), 1);

    // 2. intervals
    pulse_st();
    repeat (11) step();
    chk("ts_before_12", int'(ts), 0);
    step();
    chk("ts_at_12", int'(ts), 1);
    repeat (7) step();
    chk("tl_before_20", int'(tl), 0);
    step();
    chk("tl_at_20", int'(tl), 1);
    repeat (5) step();
    chk("ts_held", int'(ts), 1);
    chk("tl_held", int'(tl), 1);
    pulse_st();
    chk("ts_after_st", int'(ts), 0);
    chk("tl_after_st", int'(tl), 0);

    // 3. st held, st on wrap cycle
    st = 1'b1;
    repeat (30) step();
    chk("held_elapsed", int'(elapsed), 0);
    chk("held_ts", int'(ts), 0);
    chk("held_tl", int'(tl), 0);
    st = 1'b0;
    repeat (3) step();
    pulse_st();
    chk("wrap_st_elapsed", int'(elapsed), 0);

    // 4. config
    pulse_st();
    repeat (16) step();
    chk("cfg_elapsed4", int'(elapsed), 4);
    chk("cfg_tl_pre", int'(tl), 0);
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_data = 8'd3;
    step();
    cfg_we = 1'b0;
    chk("cfg_tl_now", int'(tl), 1);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd0; st = 1'b1;
    step();
    cfg_we = 1'b0; st = 1'b0;
    chk("cfg_st_ts", int'(ts), 0);
    chk("cfg_st_tl", int'(tl), 0);
    repeat (3) step();
    chk("ts0_before_4", int'(ts), 0);
    step();
    chk("ts0_at_4", int'(ts), 1);

    // 5. debounce
    car_raw = 1'b1;
    repeat (3) step();
    car_raw = 1'b0;
    repeat (10) step();
    chk("glitch_c", int'(c), 0);
    car_raw = 1'b1;
    repeat (5) step();
    chk("rise_c_5", int'(c), 0);
    step();
    chk("rise_c_6", int'(c), 1);
    repeat (4) step();
    car_raw = 1'b0;
    repeat (5) step();
    chk("fall_c_5", int'(c), 1);
    step();
    chk("fall_c_6", int'(c), 0);

    // 6. saturation and mid-interval reset
    pulse_st();
    repeat (1210) step();
    chk("sat_elapsed", int'(elapsed), 255);
    chk("sat_tl", int'(tl), 1);
    car_raw = 1'b1;
    repeat (8) step();
    pulse_st();
    repeat (10) step();
    chk("pre_rst_c", int'(c), 1);
    rst_n = 1'b0; car_raw = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_ts", int'(ts), 0);
    chk("mid_rst_tl", int'(tl), 0);
    chk("mid_rst_c", int'(c), 0);
    chk("mid_rst_elapsed", int'(elapsed), 0);
    repeat (11) step();
    chk("def_ts_before", int'(ts), 0);
    step();
    chk("def_ts_at", int'(ts), 1);
    repeat (7) step();
    chk("def_tl_before", int'(tl), 0);
    step();
    chk("def_tl_at", int'(tl), 1);

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
